// File: rtl/sample_frame_packetizer.sv
// Drains the capture FIFO on pause and emits one framed byte stream:
// header, 16-bit samples MSB-first, trailer, 16-bit sample count.
module sample_frame_packetizer #(
  parameter int          DATA_W   = 12,
  parameter int          CNT_W    = 16,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter logic [7:0]  TRL_BYTE = 8'h5A
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        capture_state,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [3:0] CAP_PAUSE = 4'b0100;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_WAIT,
    S_SHI,
    S_SLO,
    S_TRL,
    S_CHI,
    S_CLO,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             xfer;
  logic             pause;

  assign xfer  = tx_valid_q & tx_ready;
  assign pause = (capture_state == CAP_PAUSE);

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    fifo_rd_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pause) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) state_d = S_RD;
      end
      S_RD: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_WAIT;
        end else begin
          state_d = S_TRL;
        end
      end
      S_WAIT: begin
        sample_d = 16'(fifo_dout);
        state_d  = S_SHI;
      end
      S_SHI: begin
        if (xfer) state_d = S_SLO;
      end
      S_SLO: begin
        if (xfer) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = S_RD;
        end
      end
      S_TRL: begin
        if (xfer) state_d = S_CHI;
      end
      S_CHI: begin
        if (xfer) state_d = S_CLO;
      end
      S_CLO: begin
        if (xfer) begin
          frame_cnt_d = cnt_q;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (!pause) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte outputs are registered against the state being entered,
  // so tx_valid rises on the same edge the state does.
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    unique case (state_d)
      S_HDR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR_BYTE;
      end
      S_SHI: begin
        tx_valid_d = 1'b1;
        tx_data_d  = sample_d[15:8];
      end
      S_SLO: begin
        tx_valid_d = 1'b1;
        tx_data_d  = sample_d[7:0];
      end
      S_TRL: begin
        tx_valid_d = 1'b1;
        tx_data_d  = TRL_BYTE;
      end
      S_CHI: begin
        tx_valid_d = 1'b1;
        tx_data_d  = cnt_d[15:8];
      end
      S_CLO: begin
        tx_valid_d = 1'b1;
        tx_data_d  = cnt_d[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      sample_q    <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sample_frame_packetizer.sv
// Directed bench: two packetizers (12- and 16-bit samples) in lockstep
// on one shared FIFO model and byte link.
module tb_sample_frame_packetizer;

  localparam logic [3:0] INIT  = 4'b0001;
  localparam logic [3:0] PAUSE = 4'b0100;

  bit          clk = 1'b0;
  logic        rstn;
  logic [3:0]  capture_state;
  logic        fifo_empty;
  logic [11:0] dout_a;
  logic [15:0] dout_b;
  logic        tx_ready;

  logic        rd_a, rd_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b;
  logic        busy_a, busy_b;
  logic [15:0] fcnt_a, fcnt_b;

  logic [15:0] fq[$];
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];

  int ncheck = 0;
  int nerr   = 0;
  int rd_cnt = 0;
  int vcnt   = 0;
  int mode   = 0;
  int stall_left = 0;
  logic stall_arm  = 1'b0;
  logic hold_low   = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  sample_frame_packetizer #(.DATA_W(12)) u12 (
    .clk(clk), .rstn(rstn),
    .capture_state(capture_state),
    .fifo_empty(fifo_empty),
    .fifo_dout(dout_a),
    .fifo_rd_en(rd_a),
    .tx_data(tx_data_a),
    .tx_valid(tx_valid_a),
    .tx_ready(tx_ready),
    .busy(busy_a),
    .frame_cnt(fcnt_a)
  );

  sample_frame_packetizer #(.DATA_W(16)) u16 (
    .clk(clk), .rstn(rstn),
    .capture_state(capture_state),
    .fifo_empty(fifo_empty),
    .fifo_dout(dout_b),
    .fifo_rd_en(rd_b),
    .tx_data(tx_data_b),
    .tx_valid(tx_valid_b),
    .tx_ready(tx_ready),
    .busy(busy_b),
    .frame_cnt(fcnt_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncheck++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: drive tx_ready, observe at negedge, model FIFO read.
  task automatic cyc();
    logic rd;
    @(negedge clk);
    if (hold_low) tx_ready = 1'b0;
    else if (mode == 1) tx_ready = ~tx_ready;
    else tx_ready = 1'b1;
    if (stall_arm && tx_valid_a && tx_data_a == 8'h0A) begin
      stall_left = 5;
      stall_arm  = 1'b0;
    end
    if (stall_left > 0) begin
      tx_ready = 1'b0;
      stall_left--;
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(tx_valid_a), 32'd1);
      chk("stall_data", 32'(tx_data_a), 32'(prev_data));
    end
    prev_stall = tx_valid_a & ~tx_ready;
    prev_data  = tx_data_a;
    if (tx_valid_a) vcnt++;
    if (tx_valid_a && tx_ready) qa.push_back(tx_data_a);
    if (tx_valid_b && tx_ready) qb.push_back(tx_data_b);
    rd = rd_a;
    if (rd_a || rd_b) begin
      chk("rd_lockstep", 32'(rd_b), 32'(rd_a));
      chk("rd_not_empty", 32'(fifo_empty), 32'd0);
      rd_cnt++;
    end
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) begin
      dout_b = fq.pop_front();
      dout_a = dout_b[11:0];
      fifo_empty = (fq.size() == 0);
    end
  endtask

  task automatic collect(input string tag, input int n);
    int b;
    b = 0;
    while (qa.size() < n && b < 300) begin
      cyc();
      b++;
    end
    chk(tag, 32'(qa.size()), 32'(n));
  endtask

  task automatic chk_bytes(input string tag, input int n,
                           input logic [63:0] e,
                           input logic sel16);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      if (sel16) g = (i < qb.size()) ? qb[i] : 8'hxx;
      else       g = (i < qa.size()) ? qa[i] : 8'hxx;
      chk(tag, 32'(g), 32'(e[8*(n-1-i) +: 8]));
    end
  endtask

  task automatic start_frame();
    qa.delete();
    qb.delete();
    rd_cnt = 0;
    capture_state = PAUSE;
  endtask

  initial begin
    rstn = 1'b0;
    capture_state = INIT;
    fifo_empty = 1'b1;
    dout_a = '0;
    dout_b = '0;
    tx_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", 32'(tx_valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_fcnt", 32'(fcnt_a), 32'd0);
    chk("rst_data", 32'(tx_data_a), 32'd0);
    chk("rst_rd", 32'(rd_a), 32'd0);
    rstn = 1'b1;
    cyc();

    // normal frame, header one cycle after pause is seen
    push(16'h0123);
    push(16'h0ABC);
    start_frame();
    cyc();
    chk("lat_valid", 32'(tx_valid_a), 32'd1);
    chk("lat_hdr", 32'(tx_data_a), 32'hA5);
    chk("lat_busy", 32'(busy_a), 32'd1);
    collect("norm_len", 8);
    chk_bytes("norm_byte", 8, 64'hA501230ABC5A0002, 1'b0);
    chk("norm_rd", 32'(rd_cnt), 32'd2);
    chk("norm_fcnt", 32'(fcnt_a), 32'd2);
    chk("norm_busy", 32'(busy_a), 32'd0);
    chk("norm_empty", 32'(fifo_empty), 32'd1);
    capture_state = INIT;
    cyc();

    // toggling ready plus a 5-cycle stall on byte 0A
    push(16'h0123);
    push(16'h0ABC);
    mode = 1;
    stall_arm = 1'b1;
    start_frame();
    collect("bp_len", 8);
    chk_bytes("bp_byte", 8, 64'hA501230ABC5A0002, 1'b0);
    chk("bp_rd", 32'(rd_cnt), 32'd2);
    chk("bp_fcnt", 32'(fcnt_a), 32'd2);
    chk("bp_stall_used", 32'(stall_arm), 32'd0);
    mode = 0;
    capture_state = INIT;
    cyc();

    // reset after third byte; the read issued in that cycle is lost
    push(16'h0123);
    push(16'h0ABC);
    push(16'h0456);
    start_frame();
    collect("rst3_len", 3);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk("mid_valid", 32'(tx_valid_a), 32'd0);
    chk("mid_rd", 32'(rd_a), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_fcnt", 32'(fcnt_a), 32'd0);
    qa.delete();
    qb.delete();
    collect("rerun_len", 6);
    chk_bytes("rerun_byte", 6, 64'hA504565A0001, 1'b0);
    chk("rerun_fcnt", 32'(fcnt_a), 32'd1);
    capture_state = INIT;
    cyc();

    // empty FIFO at pause entry
    start_frame();
    collect("empty_len", 4);
    chk_bytes("empty_byte", 4, 64'hA55A0000, 1'b0);
    chk("empty_rd", 32'(rd_cnt), 32'd0);
    chk("empty_fcnt", 32'(fcnt_a), 32'd0);

    // pause held: no second frame
    vcnt = 0;
    repeat (200) cyc();
    chk("hold_valid", 32'(vcnt), 32'd0);
    chk("hold_busy", 32'(busy_a), 32'd0);
    capture_state = INIT;
    cyc();

    // 16-bit full-scale sample and counter saturation
    push(16'hFFFF);
    start_frame();
    collect("sat_pre_len", 2);
    hold_low = 1'b1;
    force u16.cnt_q = 16'hFFFF;
    cyc();
    release u16.cnt_q;
    hold_low = 1'b0;
    collect("sat_len", 6);
    chk_bytes("sat16_byte", 6, 64'hA5FFFF5AFFFF, 1'b1);
    chk_bytes("sat12_byte", 6, 64'hA50FFF5A0001, 1'b0);
    chk("sat16_fcnt", 32'(fcnt_b), 32'hFFFF);
    chk("sat12_fcnt", 32'(fcnt_a), 32'd1);
    chk("sat_busy", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end

endmodule
